// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if: stall, redirect and interrupt-entry signals between the pipeline and its controller.
interface pipe_ctrl_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int STALL_W    = 6
);
  logic                  stallreq_if_i;
  logic                  stallreq_id_i;
  logic                  stallreq_ex_i;
  logic                  stallreq_mem_i;
  logic                  jump_req_i;
  logic [ADDR_WIDTH-1:0] jump_addr_i;
  logic                  mret_i;
  logic [ADDR_WIDTH-1:0] mepc_i;
  logic                  int_req_i;
  logic                  int_en_i;
  logic [ADDR_WIDTH-1:0] int_vec_i;
  logic [ADDR_WIDTH-1:0] ex_pc_i;
  logic [STALL_W-1:0]    stall_o;
  logic                  flush_jump_o;
  logic                  flush_int_o;
  logic [ADDR_WIDTH-1:0] new_pc_o;
  logic                  epc_we_o;
  logic [ADDR_WIDTH-1:0] epc_o;
  logic                  int_ack_o;
  modport slave (
    input  stallreq_if_i, stallreq_id_i, stallreq_ex_i, stallreq_mem_i,
    input  jump_req_i, jump_addr_i, mret_i, mepc_i,
    input  int_req_i, int_en_i, int_vec_i, ex_pc_i,
    output stall_o, flush_jump_o, flush_int_o, new_pc_o, epc_we_o, epc_o, int_ack_o
  );
  modport master (
    output stallreq_if_i, stallreq_id_i, stallreq_ex_i, stallreq_mem_i,
    output jump_req_i, jump_addr_i, mret_i, mepc_i,
    output int_req_i, int_en_i, int_vec_i, ex_pc_i,
    input  stall_o, flush_jump_o, flush_int_o, new_pc_o, epc_we_o, epc_o, int_ack_o
  );
endinterface

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: merges stage stalls, arbitrates PC redirects and sequences interrupt entry.
// Interrupt entry runs IDLE -> DRAIN -> SAVE -> REDIR; redirects seen while draining become the EPC.
module pipe_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int STALL_W    = 6
) (
  input logic       clk_i,
  input logic       rst_ni,
  pipe_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, DRAIN, SAVE, REDIR} state_t;
  state_t                state_q, state_d;
  logic                  pend_jmp_q, pend_jmp_d;
  logic [ADDR_WIDTH-1:0] pend_epc_q, pend_epc_d;
  logic                  redirect;
  logic [ADDR_WIDTH-1:0] jump_tgt;
  logic [STALL_W-1:0]    merged;
  assign redirect = bus.jump_req_i | bus.mret_i;
  assign jump_tgt = bus.jump_req_i ? bus.jump_addr_i : bus.mepc_i;
  assign merged   = bus.stallreq_mem_i ? STALL_W'(5'b11111) :
                    bus.stallreq_ex_i  ? STALL_W'(4'b1111)  :
                    bus.stallreq_id_i  ? STALL_W'(3'b111)   :
                    bus.stallreq_if_i  ? STALL_W'(2'b11)    : '0;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      pend_jmp_q <= 1'b0;
      pend_epc_q <= '0;
    end else begin
      state_q    <= state_d;
      pend_jmp_q <= pend_jmp_d;
      pend_epc_q <= pend_epc_d;
    end
  end
  always_comb begin
    state_d    = state_q;
    pend_jmp_d = pend_jmp_q;
    pend_epc_d = pend_epc_q;
    case (state_q)
      IDLE:  state_d = (bus.int_req_i & bus.int_en_i & !redirect) ? DRAIN : IDLE;
      DRAIN: begin
        // The redirected-to instruction never executes, so it is where the handler must return.
        if (redirect) begin
          pend_jmp_d = 1'b1;
          pend_epc_d = jump_tgt;
        end
        state_d = (!bus.stallreq_ex_i && !bus.stallreq_mem_i) ? SAVE : DRAIN;
      end
      SAVE:  state_d = REDIR;
      default: begin
        state_d    = IDLE;
        pend_jmp_d = 1'b0;
      end
    endcase
  end
  always_comb begin
    bus.stall_o      = state_q == REDIR ? '0 :
                       state_q == SAVE  ? STALL_W'(3'b111) :
                       state_q == DRAIN ? merged | STALL_W'(3'b111) : merged;
    bus.flush_int_o  = state_q == REDIR;
    bus.flush_jump_o = redirect && state_q != REDIR;
    bus.new_pc_o     = state_q == REDIR ? bus.int_vec_i : redirect ? jump_tgt : '0;
    bus.epc_we_o     = state_q == SAVE;
    bus.epc_o        = state_q == SAVE ? (pend_jmp_q ? pend_epc_q : bus.ex_pc_i) : '0;
    bus.int_ack_o    = state_q == REDIR;
  end
endmodule
